// File: rtl/moxie_wb_arbiter.sv
// Wishbone N-master to 1-slave arbiter with bus lock, fixed or round-robin
// priority, and a per-transfer ack timeout that reports an error to the owner.
module moxie_wb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DW          = 16,
    parameter int AW          = 32,
    parameter int SELW        = DW / 8,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*SELW-1:0] m_sel_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [SELW-1:0]             s_sel_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        busy_o
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, OWNED} state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IW-1:0]          owner_q;
    logic [IW-1:0]          last_q;
    logic [CW-1:0]          cnt_q;

    logic                   win_vld;
    logic [IW-1:0]          win_idx;
    logic                   owned;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   tmo_hit;

    // Pick the winner; round-robin starts one past the previous owner and wraps.
    always_comb begin
        int cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (RR_MODE != 0) ? ((int'(last_q) + 1 + i) % NUM_MASTERS) : i;
            if (!win_vld && m_cyc_i[cand]) begin
                win_vld = 1'b1;
                win_idx = IW'(cand);
            end
        end
    end

    assign owned   = (state_q == OWNED);
    assign own_cyc = m_cyc_i[owner_q];
    assign own_stb = m_stb_i[owner_q];
    assign tmo_hit = (TIMEOUT != 0) && owned && own_stb && !s_ack_i
                     && (cnt_q == CW'(TIMEOUT - 1));

    assign s_cyc_o = owned & own_cyc;
    assign s_stb_o = owned & own_stb & ~tmo_hit;
    assign s_we_o  = owned & m_we_i[owner_q];
    assign s_adr_o = owned ? m_adr_i[int'(owner_q)*AW +: AW] : '0;
    assign s_dat_o = owned ? m_dat_i[int'(owner_q)*DW +: DW] : '0;
    assign s_sel_o = owned ? m_sel_i[int'(owner_q)*SELW +: SELW] : '0;

    assign m_dat_o = s_dat_i;
    assign m_ack_o = {NUM_MASTERS{s_ack_i}} & grant_q;
    assign m_err_o = tmo_hit ? grant_q : '0;
    assign grant_o = grant_q;
    assign busy_o  = owned;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (win_vld) begin
                        state_q <= OWNED;
                        grant_q <= NUM_MASTERS'(1) << win_idx;
                        owner_q <= win_idx;
                        last_q  <= win_idx;
                    end
                end
                OWNED: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        cnt_q   <= '0;
                    end else if (s_ack_i || tmo_hit) begin
                        cnt_q <= '0;
                    end else if (own_stb && TIMEOUT != 0) begin
                        // Stalled strobe: count toward the timeout.
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Bench for moxie_wb_arbiter: a 2-master fixed-priority instance with a short
// timeout and a 3-master round-robin instance with the timeout disabled.
module tb_moxie_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: NUM_MASTERS=2, fixed priority, TIMEOUT=4
    logic [1:0]  a_cyc = '0, a_stb = '0, a_we = '0;
    logic [63:0] a_adr = '0;
    logic [31:0] a_dat = '0;
    logic [3:0]  a_sel = '0;
    logic [15:0] a_sdat = '0;
    logic        a_sack = 1'b0;
    logic [15:0] a_mdat, a_sdato;
    logic [1:0]  a_ack, a_err, a_grant, a_ssel;
    logic        a_scyc, a_sstb, a_swe, a_busy;
    logic [31:0] a_sadr;

    // Instance B: NUM_MASTERS=3, round-robin, TIMEOUT=0
    logic [2:0]  b_cyc = '0, b_stb = '0, b_we = '0;
    logic [95:0] b_adr = '0;
    logic [47:0] b_dat = '0;
    logic [5:0]  b_sel = '0;
    logic [15:0] b_sdat = '0;
    logic        b_sack = 1'b0;
    logic [15:0] b_mdat, b_sdato;
    logic [2:0]  b_ack, b_err, b_grant;
    logic [1:0]  b_ssel;
    logic        b_scyc, b_sstb, b_swe, b_busy;
    logic [31:0] b_sadr;

    moxie_wb_arbiter #(.NUM_MASTERS(2), .DW(16), .AW(32), .RR_MODE(0), .TIMEOUT(4)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we),
        .m_adr_i(a_adr), .m_dat_i(a_dat), .m_sel_i(a_sel),
        .m_dat_o(a_mdat), .m_ack_o(a_ack), .m_err_o(a_err),
        .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe),
        .s_adr_o(a_sadr), .s_dat_o(a_sdato), .s_sel_o(a_ssel),
        .s_dat_i(a_sdat), .s_ack_i(a_sack),
        .grant_o(a_grant), .busy_o(a_busy)
    );

    moxie_wb_arbiter #(.NUM_MASTERS(3), .DW(16), .AW(32), .RR_MODE(1), .TIMEOUT(0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we),
        .m_adr_i(b_adr), .m_dat_i(b_dat), .m_sel_i(b_sel),
        .m_dat_o(b_mdat), .m_ack_o(b_ack), .m_err_o(b_err),
        .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe),
        .s_adr_o(b_sadr), .s_dat_o(b_sdato), .s_sel_o(b_ssel),
        .s_dat_i(b_sdat), .s_ack_i(b_sack),
        .grant_o(b_grant), .busy_o(b_busy)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model state: owner index (-1 = nobody), last owner, consecutive stalled strobes.
    int own_a = -1, last_a = 1, run_a = 0;
    int own_b = -1, last_b = 2, run_b = 0;

    task automatic step(input int n, input int rr, input int tmo,
                        input logic [7:0] cyc, input logic [7:0] stb, input logic sack,
                        input int own_i, input int last_i, input int run_i,
                        output int own, output int last, output int run);
        own = own_i; last = last_i; run = run_i;
        if (own < 0) begin
            run = 0;
            for (int i = 0; i < n; i++) begin
                int c;
                c = (rr != 0) ? (last_i + 1 + i) % n : i;
                if (cyc[c]) begin
                    own = c; last = c;
                    break;
                end
            end
        end else if (!cyc[own]) begin
            own = -1; run = 0;
        end else if (sack) begin
            run = 0;
        end else if (stb[own]) begin
            run = (tmo != 0 && run + 1 == tmo) ? 0 : run + 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        int o, l, r;
        if (rst) begin
            own_a <= -1; last_a <= 1; run_a <= 0;
            own_b <= -1; last_b <= 2; run_b <= 0;
        end else begin
            step(2, 0, 4, 8'(a_cyc), 8'(a_stb), a_sack, own_a, last_a, run_a, o, l, r);
            own_a <= o; last_a <= l; run_a <= r;
            step(3, 1, 0, 8'(b_cyc), 8'(b_stb), b_sack, own_b, last_b, run_b, o, l, r);
            own_b <= o; last_b <= l; run_b <= r;
        end
    end

    task automatic cmp(input string t, input int tmo, input int own, input int run,
                       input logic [7:0] cyc, input logic [7:0] stb, input logic [7:0] we,
                       input logic [255:0] adr, input logic [127:0] dat, input logic [15:0] sel,
                       input logic [15:0] sdat, input logic sack,
                       input logic [7:0] grant, input logic [7:0] ack, input logic [7:0] err,
                       input logic busy, input logic scyc, input logic sstb, input logic swe,
                       input logic [31:0] sadr, input logic [15:0] sdato, input logic [1:0] ssel,
                       input logic [15:0] mdat);
        logic [7:0]  eg, ea, ee;
        logic        eb, ec, es, ew, hit;
        logic [31:0] ead;
        logic [15:0] edt;
        logic [1:0]  esl;
        eg = '0; ea = '0; ee = '0; eb = 0; ec = 0; es = 0; ew = 0; hit = 0;
        ead = '0; edt = '0; esl = '0;
        if (own >= 0) begin
            eg  = 8'(1) << own;
            eb  = 1'b1;
            hit = (tmo != 0) && stb[own] && !sack && (run + 1 == tmo);
            ec  = cyc[own];
            es  = stb[own] && !hit;
            ew  = we[own];
            ead = adr[own*32 +: 32];
            edt = dat[own*16 +: 16];
            esl = sel[own*2 +: 2];
            ea  = sack ? eg : 8'h0;
            ee  = hit ? eg : 8'h0;
        end
        check({t, "grant"}, 64'(grant), 64'(eg));
        check({t, "busy"},  64'(busy),  64'(eb));
        check({t, "ack"},   64'(ack),   64'(ea));
        check({t, "err"},   64'(err),   64'(ee));
        check({t, "s_cyc"}, 64'(scyc),  64'(ec));
        check({t, "s_stb"}, 64'(sstb),  64'(es));
        check({t, "s_we"},  64'(swe),   64'(ew));
        check({t, "s_adr"}, 64'(sadr),  64'(ead));
        check({t, "s_dat"}, 64'(sdato), 64'(edt));
        check({t, "s_sel"}, 64'(ssel),  64'(esl));
        check({t, "m_dat"}, 64'(mdat),  64'(sdat));
    endtask

    always @(negedge clk) begin
        cmp("A.", 4, own_a, run_a, 8'(a_cyc), 8'(a_stb), 8'(a_we), 256'(a_adr), 128'(a_dat),
            16'(a_sel), a_sdat, a_sack, 8'(a_grant), 8'(a_ack), 8'(a_err), a_busy, a_scyc,
            a_sstb, a_swe, a_sadr, a_sdato, a_ssel, a_mdat);
        cmp("B.", 0, own_b, run_b, 8'(b_cyc), 8'(b_stb), 8'(b_we), 256'(b_adr), 128'(b_dat),
            16'(b_sel), b_sdat, b_sack, 8'(b_grant), 8'(b_ack), 8'(b_err), b_busy, b_scyc,
            b_sstb, b_swe, b_sadr, b_sdato, b_ssel, b_mdat);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] rr_seq [4];
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        a_adr  = {32'hB000_0002, 32'hA000_0001};
        a_dat  = {16'h2222, 16'h1111};
        a_sel  = {2'b10, 2'b01};
        a_we   = 2'b10;
        a_sdat = 16'hCAFE;
        b_adr  = {32'h0000_0333, 32'h0000_0222, 32'h0000_0111};
        b_dat  = {16'h3333, 16'h2222, 16'h1111};
        b_sel  = {2'b11, 2'b10, 2'b01};
        b_we   = 3'b101;
        b_sdat = 16'h5A5A;
        #12 rst = 1'b0;
        check("reset grant A", 64'(a_grant), 64'h0);
        check("reset busy B", 64'(b_busy), 64'h0);

        // Fixed priority with both masters requesting; master 0 locks the bus for 4 beats.
        a_cyc = 2'b11; a_stb = 2'b11; a_sack = 1'b1;
        #1;
        check("idle ack A", 64'(a_ack), 64'h0);
        tick();
        check("fp first grant", 64'(a_grant), 64'h1);
        check("fp s_adr", 64'(a_sadr), 64'hA000_0001);
        for (int k = 0; k < 4; k++) begin
            check("lock grant", 64'(a_grant), 64'h1);
            check("lock ack", 64'(a_ack), 64'h1);
            if (k < 3) tick();
        end
        a_cyc = 2'b10;
        tick();
        check("release idle", 64'(a_grant), 64'h0);
        tick();
        check("fp second grant", 64'(a_grant), 64'h2);
        check("m1 s_we", 64'(a_swe), 64'h1);
        check("m1 ack", 64'(a_ack), 64'h2);
        a_cyc = 2'b00; a_sack = 1'b0;
        tick();
        tick();

        // Timeout on A: slave never acks; error on the 4th stalled cycle, then restarts.
        a_cyc = 2'b01; a_stb = 2'b01;
        tick();
        check("tmo c1 err", 64'(a_err), 64'h0);
        tick(); tick(); tick();
        check("tmo c4 err", 64'(a_err), 64'h1);
        check("tmo c4 stb", 64'(a_sstb), 64'h0);
        check("tmo c4 grant", 64'(a_grant), 64'h1);
        tick();
        check("tmo restart err", 64'(a_err), 64'h0);
        check("tmo restart stb", 64'(a_sstb), 64'h1);
        tick(); tick(); tick();
        a_sack = 1'b1;
        #1;
        check("tmo vs ack ack", 64'(a_ack), 64'h1);
        check("tmo vs ack err", 64'(a_err), 64'h0);
        a_sack = 1'b0; a_cyc = 2'b00; a_stb = 2'b00;
        tick();
        tick();

        // Round-robin on B: everyone requests, owner releases after one acked beat.
        b_stb = 3'b111; b_sack = 1'b1; b_cyc = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("rr grant", 64'(b_grant), 64'(rr_seq[k]));
            check("rr ack", 64'(b_ack), 64'(rr_seq[k]));
            b_cyc = 3'b111 & ~rr_seq[k];
            tick();
            check("rr gap", 64'(b_grant), 64'h0);
            b_cyc = 3'b111;
            tick();
        end
        b_cyc = 3'b000; b_sack = 1'b0;
        tick();
        tick();

        // Timeout disabled on B: a long stall never raises err.
        b_cyc = 3'b001; b_stb = 3'b001;
        tick();
        repeat (12) tick();
        check("no tmo err", 64'(b_err), 64'h0);
        check("no tmo stb", 64'(b_sstb), 64'h1);

        // Reset mid-transfer clears everything at once; RR restarts from master 0.
        b_sack = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst grant", 64'(b_grant), 64'h0);
        check("rst busy", 64'(b_busy), 64'h0);
        check("rst s_cyc", 64'(b_scyc), 64'h0);
        check("rst s_stb", 64'(b_sstb), 64'h0);
        check("rst s_adr", 64'(b_sadr), 64'h0);
        check("rst ack", 64'(b_ack), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        b_cyc = 3'b111; b_sack = 1'b0;
        tick();
        check("post rst rr", 64'(b_grant), 64'h1);
        b_cyc = 3'b000; b_stb = 3'b000;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/moxie_wb_arbiter.md
MOXIE_WB_ARBITER -- requirements
Module: moxie_wb_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_MASTERS, 2, number of Wishbone masters (2..8)
- DW, 16, data width
- AW, 32, address width
- SELW, DW/8, byte-select width
- RR_MODE, 0, 0 = fixed priority (master 0 highest), 1 = round-robin
- TIMEOUT, 255, cycles without ack before error (0 = disabled)
REQ-002 Ports SHALL be (name direction width meaning):
- clk_i  in  1  clock
- rst_i  in  1  reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*AW  packed addresses, master k at [k*AW +: AW]
- m_dat_i  in  NUM_MASTERS*DW  packed write data
- m_sel_i  in  NUM_MASTERS*SELW  packed byte selects
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master timeout error
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_sel_o  out  SELW  slave byte select
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  NUM_MASTERS  one-hot current owner
- busy_o  out  1  bus owned
REQ-003 Reset rst_i SHALL be asynchronous, active-high; clock clk_i.

Function
REQ-004 The state machine SHALL have two states: IDLE (no grant) and OWNED (exactly one grant bit set).
REQ-005 In IDLE with any m_cyc_i set, the arbiter SHALL register a one-hot grant at the next edge and enter OWNED; arbitration latency is 1 cycle.
REQ-006 RR_MODE=0: the lowest-indexed requesting master SHALL win.
REQ-007 RR_MODE=1: search SHALL start at (last_owner+1) mod NUM_MASTERS and wrap; last_owner SHALL update on each grant.
REQ-008 In OWNED, the grant SHALL be held while the owner's m_cyc_i stays high (bus lock across multi-beat transfers); other requests SHALL be ignored.
REQ-009 When the owner drops m_cyc_i, the arbiter SHALL return to IDLE at that edge with grant cleared; re-arbitration SHALL occur on the following edge.
REQ-010 s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o SHALL be combinationally muxed from the owner; with no grant, all SHALL be 0.
REQ-011 s_cyc_o SHALL be gated by the owner's live m_cyc_i.
REQ-012 m_ack_o[k] SHALL equal s_ack_i & grant_o[k]; non-owners SHALL never see ack.
REQ-013 m_dat_o SHALL equal s_dat_i unconditionally.
REQ-014 The timeout counter SHALL count cycles in OWNED with s_stb_o=1 and s_ack_i=0, and clear on ack, on leaving OWNED, or on timeout.
REQ-015 When the counter reaches TIMEOUT (nonzero), the arbiter SHALL pulse m_err_o[owner] for one cycle, force s_stb_o=0 that cycle, and keep the grant.
REQ-016 If s_ack_i and timeout coincide, the ack SHALL win; no err is issued.
REQ-017 busy_o SHALL equal (state == OWNED).

Reset
REQ-018 On rst_i, the arbiter SHALL enter IDLE with grant_o=0, busy_o=0, m_err_o=0, counter=0, and last_owner=NUM_MASTERS-1 (so master 0 wins first in RR).
REQ-019 Reset mid-transfer SHALL immediately drive all slave-side outputs and m_ack_o to 0.

Verification
REQ-020 N=2, fixed priority: m_cyc_i=2'b11 from IDLE -> grant_o=2'b01 one cycle later; master1 waits until master0 drops cyc.
REQ-021 N=3, RR_MODE=1: all three request continuously, each releasing after one acked beat -> grant sequence 001, 010, 100, 001.
REQ-022 Master0 holds cyc through 4 beats while master1 requests -> grant stays 01; m_ack_o[1] is never asserted.
REQ-023 TIMEOUT=4, slave never acks -> m_err_o[owner] pulses on the 4th stalled cycle with s_stb_o=0 that cycle; the counter restarts.
REQ-024 TIMEOUT=4, ack on the same cycle as expiry -> m_ack_o asserted, m_err_o=0.
REQ-025 Assert rst_i while OWNED with stb high -> all outputs 0 asynchronously; after release, RR grants master 0 first.
